// File: rtl/vip_edge_bbox_overlay.sv
// vip_edge_bbox_overlay
//   Sits after the Sobel edge detector in the camera-to-HDMI path. It collects
//   the bounding box of all edge pixels in a frame and latches it at the next
//   frame start. It then draws that box as a coloured rectangle on the
//   following frame's pixels.
//
// Ports
//   clk, rst                 pixel clock, asynchronous active-high reset
//   per_frame_vsync/href/    incoming video timing
//   per_frame_clken
//   per_frame_data[23:0]     edge pixel, bit 23 is the edge flag
//   post_frame_vsync/href/   timing delayed by one cycle
//   post_frame_clken
//   post_frame_data[23:0]    pixel with the box overlay, one cycle latency
//   box_left/right/top/bottom   box latched at the last frame boundary
//   box_valid                the latched box had at least MIN_EDGE_CNT edges
//   edge_count               edge pixel count of the last frame
//
// Pixel handshake: a pixel transfers on every cycle where
// per_frame_href & per_frame_clken is high. There is no backpressure, so the
// stream must be consumed on every cycle.
module vip_edge_bbox_overlay #(
  parameter int          IMG_W        = 640,
  parameter int          IMG_H        = 480,
  parameter logic [23:0] BOX_COLOR    = 24'hFF0000,
  parameter int          MIN_EDGE_CNT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        per_frame_vsync,
  input  logic        per_frame_href,
  input  logic        per_frame_clken,
  input  logic [23:0] per_frame_data,
  output logic        post_frame_vsync,
  output logic        post_frame_href,
  output logic        post_frame_clken,
  output logic [23:0] post_frame_data,
  output logic [10:0] box_left,
  output logic [10:0] box_right,
  output logic [10:0] box_top,
  output logic [10:0] box_bottom,
  output logic        box_valid,
  output logic [19:0] edge_count
);

  localparam logic [10:0] W_LIM     = 11'(IMG_W);
  localparam logic [10:0] H_LIM     = 11'(IMG_H);
  localparam logic [10:0] XMIN_INIT = 11'(IMG_W - 1);
  localparam logic [10:0] YMIN_INIT = 11'(IMG_H - 1);
  localparam logic [19:0] MIN_CNT   = 20'(MIN_EDGE_CNT);
  localparam logic [10:0] CNT11_MAX = 11'h7FF;
  localparam logic [19:0] CNT20_MAX = 20'hFFFFF;

  logic        vsync_q, href_q;
  logic [10:0] x_q, x_d, y_q, y_d;
  logic [10:0] acc_xmin_q, acc_xmin_d, acc_xmax_q, acc_xmax_d;
  logic [10:0] acc_ymin_q, acc_ymin_d, acc_ymax_q, acc_ymax_d;
  logic [19:0] acc_cnt_q, acc_cnt_d;
  logic [10:0] box_left_q, box_left_d, box_right_q, box_right_d;
  logic [10:0] box_top_q, box_top_d, box_bottom_q, box_bottom_d;
  logic        box_valid_q, box_valid_d;
  logic [19:0] edge_count_q, edge_count_d;
  logic        post_vsync_q, post_href_q, post_clken_q;
  logic [23:0] post_data_q, post_data_d;

  logic pix_valid, href_fall, frame_end, in_frame, edge_hit, border_hit;

  assign pix_valid = per_frame_href & per_frame_clken;
  assign href_fall = href_q & ~per_frame_href;
  // Frame boundary: vsync rising edge, found against the registered copy.
  assign frame_end = per_frame_vsync & ~vsync_q;
  assign in_frame  = (x_q < W_LIM) && (y_q < H_LIM);
  assign edge_hit  = pix_valid & in_frame & per_frame_data[23];

  // Pixel position counters. x_q/y_q hold the position of the current pixel.
  always_comb begin
    x_d = x_q;
    if (href_fall) begin
      x_d = '0;
    end else if (pix_valid && (x_q != CNT11_MAX)) begin
      x_d = x_q + 11'd1;
    end

    y_d = y_q;
    if (frame_end) begin
      y_d = '0;  // takes priority over a coincident line end
    end else if (href_fall && (y_q != CNT11_MAX)) begin
      y_d = y_q + 11'd1;
    end
  end

  // Accumulators. On a frame boundary they restart from their init values
  // first, so a pixel arriving in that same cycle counts toward the new frame.
  always_comb begin
    acc_xmin_d = frame_end ? XMIN_INIT : acc_xmin_q;
    acc_xmax_d = frame_end ? 11'd0     : acc_xmax_q;
    acc_ymin_d = frame_end ? YMIN_INIT : acc_ymin_q;
    acc_ymax_d = frame_end ? 11'd0     : acc_ymax_q;
    acc_cnt_d  = frame_end ? 20'd0     : acc_cnt_q;
    if (edge_hit) begin
      if (x_q < acc_xmin_d) acc_xmin_d = x_q;
      if (x_q > acc_xmax_d) acc_xmax_d = x_q;
      if (y_q < acc_ymin_d) acc_ymin_d = y_q;
      if (y_q > acc_ymax_d) acc_ymax_d = y_q;
      if (acc_cnt_d != CNT20_MAX) acc_cnt_d = acc_cnt_d + 20'd1;
    end
  end

  // Latch the finished frame's result. If the frame had too few edges, the
  // old coordinates are kept but marked invalid.
  always_comb begin
    box_left_d   = box_left_q;
    box_right_d  = box_right_q;
    box_top_d    = box_top_q;
    box_bottom_d = box_bottom_q;
    box_valid_d  = box_valid_q;
    edge_count_d = edge_count_q;
    if (frame_end) begin
      edge_count_d = acc_cnt_q;
      if (acc_cnt_q >= MIN_CNT) begin
        box_left_d   = acc_xmin_q;
        box_right_d  = acc_xmax_q;
        box_top_d    = acc_ymin_q;
        box_bottom_d = acc_ymax_q;
        box_valid_d  = 1'b1;
      end else begin
        box_valid_d  = 1'b0;
      end
    end
  end

  // Overlay test, evaluated at the current pixel position.
  always_comb begin
    border_hit = 1'b0;
    if (box_valid_q) begin
      if (((y_q == box_top_q) || (y_q == box_bottom_q)) &&
          (x_q >= box_left_q) && (x_q <= box_right_q)) begin
        border_hit = 1'b1;
      end
      if (((x_q == box_left_q) || (x_q == box_right_q)) &&
          (y_q >= box_top_q) && (y_q <= box_bottom_q)) begin
        border_hit = 1'b1;
      end
    end

    post_data_d = '0;
    if (per_frame_href) begin
      post_data_d = border_hit ? BOX_COLOR : per_frame_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsync_q      <= 1'b0;
      href_q       <= 1'b0;
      x_q          <= '0;
      y_q          <= '0;
      acc_xmin_q   <= XMIN_INIT;
      acc_xmax_q   <= '0;
      acc_ymin_q   <= YMIN_INIT;
      acc_ymax_q   <= '0;
      acc_cnt_q    <= '0;
      box_left_q   <= '0;
      box_right_q  <= '0;
      box_top_q    <= '0;
      box_bottom_q <= '0;
      box_valid_q  <= 1'b0;
      edge_count_q <= '0;
      post_vsync_q <= 1'b0;
      post_href_q  <= 1'b0;
      post_clken_q <= 1'b0;
      post_data_q  <= '0;
    end else begin
      vsync_q      <= per_frame_vsync;
      href_q       <= per_frame_href;
      x_q          <= x_d;
      y_q          <= y_d;
      acc_xmin_q   <= acc_xmin_d;
      acc_xmax_q   <= acc_xmax_d;
      acc_ymin_q   <= acc_ymin_d;
      acc_ymax_q   <= acc_ymax_d;
      acc_cnt_q    <= acc_cnt_d;
      box_left_q   <= box_left_d;
      box_right_q  <= box_right_d;
      box_top_q    <= box_top_d;
      box_bottom_q <= box_bottom_d;
      box_valid_q  <= box_valid_d;
      edge_count_q <= edge_count_d;
      post_vsync_q <= per_frame_vsync;
      post_href_q  <= per_frame_href;
      post_clken_q <= per_frame_clken;
      post_data_q  <= post_data_d;
    end
  end

  assign post_frame_vsync = post_vsync_q;
  assign post_frame_href  = post_href_q;
  assign post_frame_clken = post_clken_q;
  assign post_frame_data  = post_data_q;
  assign box_left         = box_left_q;
  assign box_right        = box_right_q;
  assign box_top          = box_top_q;
  assign box_bottom       = box_bottom_q;
  assign box_valid        = box_valid_q;
  assign edge_count       = edge_count_q;

endmodule

// File: tb/tb_vip_edge_bbox_overlay.sv
// Testbench for vip_edge_bbox_overlay on a 16x8 image with a minimum edge
// count of 4. Frames are driven with edge pixels at chosen positions. The
// latched box is compared with hand-computed constants, and every output
// cycle is compared with the expected pass-through or box-colour pixel.
module tb_vip_edge_bbox_overlay;

  localparam logic [23:0] COLOR = 24'hFF0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        per_frame_vsync, per_frame_href, per_frame_clken;
  logic [23:0] per_frame_data;
  logic        post_frame_vsync, post_frame_href, post_frame_clken;
  logic [23:0] post_frame_data;
  logic [10:0] box_left, box_right, box_top, box_bottom;
  logic        box_valid;
  logic [19:0] edge_count;

  always #5 clk = ~clk;

  vip_edge_bbox_overlay #(
    .IMG_W(16), .IMG_H(8), .BOX_COLOR(COLOR), .MIN_EDGE_CNT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .per_frame_vsync(per_frame_vsync), .per_frame_href(per_frame_href),
    .per_frame_clken(per_frame_clken), .per_frame_data(per_frame_data),
    .post_frame_vsync(post_frame_vsync), .post_frame_href(post_frame_href),
    .post_frame_clken(post_frame_clken), .post_frame_data(post_frame_data),
    .box_left(box_left), .box_right(box_right), .box_top(box_top),
    .box_bottom(box_bottom), .box_valid(box_valid), .edge_count(edge_count)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic        have_exp = 1'b0;
  logic [23:0] exp_data;
  logic [2:0]  exp_ctrl;
  // Box the DUT is expected to draw on the current frame.
  logic        m_valid = 1'b0;
  int          m_l, m_r, m_t, m_b;
  logic        em [0:17][0:8];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic border(input int x, input int y);
    if (!m_valid) return 1'b0;
    return (((y == m_t) || (y == m_b)) && (x >= m_l) && (x <= m_r)) ||
           (((x == m_l) || (x == m_r)) && (y >= m_t) && (y <= m_b));
  endfunction

  function automatic logic [23:0] pix(input int x, input int y);
    return {em[x][y], 7'h0, 8'(y), 8'(x)};
  endfunction

  task automatic clear_edges();
    for (int i = 0; i < 18; i++)
      for (int j = 0; j < 9; j++) em[i][j] = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  // One clock cycle. First check the outputs produced by the previous cycle's
  // inputs, then drive new inputs and record what they should produce.
  task automatic cycle(input logic vs, input logic hr, input logic [23:0] d,
                       input int x, input int y, input logic r);
    @(negedge clk);
    if (have_exp) begin
      check("post_data", {8'h0, post_frame_data}, {8'h0, exp_data});
      check("post_ctrl", {29'h0, post_frame_vsync, post_frame_href, post_frame_clken},
            {29'h0, exp_ctrl});
    end
    rst             = r;
    per_frame_vsync = vs;
    per_frame_href  = hr;
    per_frame_clken = hr;
    per_frame_data  = d;
    exp_ctrl = r ? 3'b000 : {vs, hr, hr};
    exp_data = (r || !hr) ? 24'h0 : (border(x, y) ? COLOR : d);
    have_exp = 1'b1;
  endtask

  task automatic line(input int y, input int len);
    for (int x = 0; x < len; x++) cycle(1'b0, 1'b1, pix(x, y), x, y, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 24'($urandom), 0, 0, 1'b0);
  endtask

  task automatic frame(input int nlines, input int len);
    for (int y = 0; y < nlines; y++) line(y, len);
  endtask

  task automatic vblank();
    for (int k = 0; k < 3; k++) cycle(1'b1, 1'b0, 24'($urandom), 0, 0, 1'b0);
    for (int k = 0; k < 2; k++) cycle(1'b0, 1'b0, 24'($urandom), 0, 0, 1'b0);
  endtask

  task automatic check_status(input string tag, input int cnt, input logic v,
                              input int l, input int r, input int t, input int b);
    check({tag, ".edge_count"}, {12'h0, edge_count}, 32'(cnt));
    check({tag, ".box_valid"},  {31'h0, box_valid},  {31'h0, v});
    check({tag, ".box_left"},   {21'h0, box_left},   32'(l));
    check({tag, ".box_right"},  {21'h0, box_right},  32'(r));
    check({tag, ".box_top"},    {21'h0, box_top},    32'(t));
    check({tag, ".box_bottom"}, {21'h0, box_bottom}, 32'(b));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; per_frame_vsync = 1'b0; per_frame_href = 1'b0;
    per_frame_clken = 1'b0; per_frame_data = '0;
    clear_edges();

    // 1. Reset with toggling inputs, then plain pass-through with no box.
    for (int k = 0; k < 6; k++)
      cycle(1'($urandom), 1'($urandom), 24'($urandom), 0, 0, 1'b1);
    check_status("reset", 0, 1'b0, 0, 0, 0, 0);
    for (int x = 0; x < 5; x++) cycle(1'b0, 1'b1, 24'h12_3400 + 24'(x), x, 0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 24'h0, 0, 0, 1'b0);
    vblank();
    check_status("empty", 0, 1'b0, 0, 0, 0, 0);

    // 2. Four edges define the box (3..10, 2..6).
    em[3][2] = 1; em[10][2] = 1; em[5][6] = 1; em[7][4] = 1;
    frame(8, 16);
    vblank();
    check_status("f1", 4, 1'b1, 3, 10, 2, 6);
    m_valid = 1'b1; m_l = 3; m_r = 10; m_t = 2; m_b = 6;

    // 3/4. Box drawn on this frame; only three edges so the next box is invalid.
    clear_edges();
    em[1][1] = 1; em[2][1] = 1; em[14][7] = 1;
    frame(8, 16);
    vblank();
    check_status("f2", 3, 1'b0, 3, 10, 2, 6);
    m_valid = 1'b0;

    // 5. Overlong lines and an extra line; edges outside 16x8 are ignored.
    clear_edges();
    em[16][1] = 1; em[17][3] = 1; em[4][8] = 1;
    em[2][3] = 1; em[12][5] = 1; em[6][1] = 1; em[9][7] = 1;
    frame(9, 18);
    vblank();
    check_status("f3", 4, 1'b1, 2, 12, 1, 7);
    m_valid = 1'b1; m_l = 2; m_r = 12; m_t = 1; m_b = 7;

    // 6. Reset after two edges, then four more edges.
    clear_edges();
    em[0][0] = 1; em[15][0] = 1;
    frame(2, 16);
    m_valid = 1'b0;
    for (int k = 0; k < 3; k++) cycle(1'b0, 1'b0, 24'($urandom), 0, 0, 1'b1);
    check_status("midrst", 0, 1'b0, 0, 0, 0, 0);
    clear_edges();
    em[4][0] = 1; em[8][1] = 1; em[6][2] = 1; em[11][3] = 1;
    frame(4, 16);
    vblank();
    check_status("f4", 4, 1'b1, 4, 11, 0, 3);
    m_valid = 1'b1; m_l = 4; m_r = 11; m_t = 0; m_b = 3;

    // Box touching the top edge is drawn; corner edges give a full-image box.
    clear_edges();
    em[0][0] = 1; em[15][0] = 1; em[0][7] = 1; em[15][7] = 1;
    frame(8, 16);
    vblank();
    check_status("f5", 4, 1'b1, 0, 15, 0, 7);
    m_valid = 1'b1; m_l = 0; m_r = 15; m_t = 0; m_b = 7;

    // Full-image border, no edges in this frame.
    clear_edges();
    frame(8, 16);
    vblank();
    check_status("f6", 0, 1'b0, 0, 15, 0, 7);
    m_valid = 1'b0;

    cycle(1'b0, 1'b0, 24'h0, 0, 0, 1'b0);

    // ---------------- final report ----------------
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
